// File: rtl/lcd_pkg.sv
// Shared command bytes, sequencer state encodings and delay helpers for the
// HD44780 4-bit text mirror.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC  = 8'h28;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] ADDR_L1   = 8'h80;
   localparam logic [7:0] ADDR_L2   = 8'hC0;

   localparam logic [3:0] NIB_WAKE  = 4'h3;
   localparam logic [3:0] NIB_4BIT  = 4'h2;

   localparam int unsigned T_PWRUP_US = 20_000;
   localparam int unsigned T_WAKE1_US = 5_000;
   localparam int unsigned T_WAKE2_US = 200;
   localparam int unsigned T_CMD_US   = 50;
   localparam int unsigned T_CLR_US   = 2_000;
   localparam int unsigned T_STEP_US  = 1;

   typedef enum logic [2:0] {
      PWRUP,
      INIT_NIB,
      INIT_BYTE,
      SET_ADDR1,
      WR_LINE1,
      SET_ADDR2,
      WR_LINE2
   } lcd_state_e;

   typedef enum logic [2:0] {
      SQ_IDLE,
      SQ_HI,
      SQ_GAP,
      SQ_LO,
      SQ_POST
   } seq_phase_e;

   typedef enum logic [1:0] {
      NT_IDLE,
      NT_SETUP,
      NT_PULSE,
      NT_HOLD
   } nib_state_e;

   typedef enum logic [1:0] {
      OP_WAIT,
      OP_NIB,
      OP_BYTE
   } op_kind_e;

   // ceil(us * freq / 1e6), never less than one cycle
   function automatic logic [31:0] us2cyc(input int unsigned us, input int unsigned freq_hz);
      longint unsigned us_l;
      longint unsigned f_l;
      longint unsigned cyc;
      us_l = us;
      f_l  = freq_hz;
      cyc  = (us_l * f_l + 64'd999_999) / 64'd1_000_000;
      if (cyc == 64'd0) begin
         cyc = 64'd1;
      end
      return 32'(cyc);
   endfunction

   // Clear and return-home need the long settle time
   function automatic logic is_slow_cmd(input logic [7:0] b);
      return (b == CMD_CLEAR) || (b[7:1] == 7'h01);
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one nibble onto the LCD bus: setup, E pulse, hold, each one microsecond.
// Accepts start only while idle; done pulses for one cycle at the end of hold.
module lcd_nibble_tx
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rs,
   input  logic [3:0] nib,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [3:0] lcd_d,
   output logic       done
);

   localparam logic [31:0] C_STEP = us2cyc(T_STEP_US, CLK_FREQ_HZ);

   nib_state_e  state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic        e_q, e_d;
   logic        rs_q, rs_d;
   logic [3:0]  d_q, d_d;
   logic        last_step;

   assign last_step = (timer_q == C_STEP - 32'd1);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      e_d     = e_q;
      rs_d    = rs_q;
      d_d     = d_q;
      done    = 1'b0;
      case (state_q)
         NT_IDLE: begin
            if (start) begin
               rs_d    = rs;
               d_d     = nib;
               timer_d = 32'd0;
               state_d = NT_SETUP;
            end
         end
         NT_SETUP: begin
            if (last_step) begin
               e_d     = 1'b1;
               timer_d = 32'd0;
               state_d = NT_PULSE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         NT_PULSE: begin
            if (last_step) begin
               e_d     = 1'b0;
               timer_d = 32'd0;
               state_d = NT_HOLD;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         NT_HOLD: begin
            // RS/D stay on the bus after E falls; they only move on the next start
            if (last_step) begin
               done    = 1'b1;
               timer_d = 32'd0;
               state_d = NT_IDLE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: begin
            state_d = NT_IDLE;
            e_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= NT_IDLE;
         timer_q <= 32'd0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         d_q     <= 4'h0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         d_q     <= d_d;
      end
   end

   assign lcd_e  = e_q;
   assign lcd_rs = rs_q;
   assign lcd_d  = d_q;

endmodule

// File: rtl/lcd_module.sv
// Mirrors row_A/row_B onto a 16x2 HD44780 over the 4-bit bus: power-on init, then
// endless refresh; each frame uses rows snapshotted as its line-1 address command starts.
module lcd_module
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] row_A,
   input  logic [127:0] row_B,
   output logic         LCD_E,
   output logic         LCD_RS,
   output logic         LCD_RW,
   output logic [3:0]   LCD_D
);

   localparam logic [31:0] C_1US   = us2cyc(T_STEP_US,  CLK_FREQ_HZ);
   localparam logic [31:0] C_PWRUP = us2cyc(T_PWRUP_US, CLK_FREQ_HZ);
   localparam logic [31:0] C_WAKE1 = us2cyc(T_WAKE1_US, CLK_FREQ_HZ);
   localparam logic [31:0] C_WAKE2 = us2cyc(T_WAKE2_US, CLK_FREQ_HZ);
   localparam logic [31:0] C_CMD   = us2cyc(T_CMD_US,   CLK_FREQ_HZ);
   localparam logic [31:0] C_CLR   = us2cyc(T_CLR_US,   CLK_FREQ_HZ);

   // Frame-level FSM
   lcd_state_e   state_q, state_d;
   logic [1:0]   idx_q, idx_d;
   logic [3:0]   col_q, col_d;
   logic [127:0] snap_a_q, snap_a_d;
   logic [127:0] snap_b_q, snap_b_d;

   // Byte/nibble/wait sequencer
   seq_phase_e   phase_q, phase_d;
   op_kind_e     kind_q, kind_d;
   logic         srs_q, srs_d;
   logic [7:0]   byte_q, byte_d;
   logic [31:0]  post_q, post_d;
   logic [31:0]  timer_q, timer_d;

   op_kind_e     op_kind;
   logic         op_rs;
   logic [7:0]   op_byte;
   logic [31:0]  op_wait;
   logic         op_go;
   logic         seq_done;

   logic         nib_start;
   logic         nib_rs;
   logic [3:0]   nib_val;
   logic         nib_done;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      col_d    = col_q;
      snap_a_d = snap_a_q;
      snap_b_d = snap_b_q;
      op_kind  = OP_BYTE;
      op_rs    = 1'b0;
      op_byte  = 8'h00;
      op_wait  = C_CMD;
      op_go    = (phase_q == SQ_IDLE);

      case (state_q)
         PWRUP: begin
            op_kind = OP_WAIT;
            op_wait = C_PWRUP;
         end
         INIT_NIB: begin
            op_kind = OP_NIB;
            op_byte = {4'h0, (idx_q == 2'd3) ? NIB_4BIT : NIB_WAKE};
            case (idx_q)
               2'd0:    op_wait = C_WAKE1;
               2'd1:    op_wait = C_WAKE2;
               2'd2:    op_wait = C_WAKE2;
               default: op_wait = C_CMD;
            endcase
         end
         INIT_BYTE: begin
            case (idx_q)
               2'd0:    op_byte = CMD_FUNC;
               2'd1:    op_byte = CMD_ENTRY;
               2'd2:    op_byte = CMD_DISP;
               default: op_byte = CMD_CLEAR;
            endcase
            op_wait = is_slow_cmd(op_byte) ? C_CLR : C_CMD;
         end
         SET_ADDR1: op_byte = ADDR_L1;
         WR_LINE1: begin
            op_rs   = 1'b1;
            op_byte = snap_a_q[{~col_q, 3'b000} +: 8];
         end
         SET_ADDR2: op_byte = ADDR_L2;
         WR_LINE2: begin
            op_rs   = 1'b1;
            op_byte = snap_b_q[{~col_q, 3'b000} +: 8];
         end
         default: op_kind = OP_WAIT;
      endcase

      // Both rows are frozen together so neither line tears mid-frame
      if (op_go && (state_q == SET_ADDR1)) begin
         snap_a_d = row_A;
         snap_b_d = row_B;
      end

      if (seq_done) begin
         case (state_q)
            PWRUP: begin
               state_d = INIT_NIB;
               idx_d   = 2'd0;
            end
            INIT_NIB: begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = INIT_BYTE;
               end
            end
            INIT_BYTE: begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = SET_ADDR1;
               end
            end
            SET_ADDR1: begin
               state_d = WR_LINE1;
               col_d   = 4'd0;
            end
            WR_LINE1: begin
               col_d = col_q + 4'd1;
               if (col_q == 4'd15) begin
                  state_d = SET_ADDR2;
               end
            end
            SET_ADDR2: begin
               state_d = WR_LINE2;
               col_d   = 4'd0;
            end
            WR_LINE2: begin
               col_d = col_q + 4'd1;
               if (col_q == 4'd15) begin
                  state_d = SET_ADDR1;
               end
            end
            default: state_d = PWRUP;
         endcase
      end
   end

   always_comb begin
      phase_d   = phase_q;
      kind_d    = kind_q;
      srs_d     = srs_q;
      byte_d    = byte_q;
      post_d    = post_q;
      timer_d   = timer_q;
      nib_start = 1'b0;
      nib_rs    = srs_q;
      nib_val   = byte_q[7:4];
      seq_done  = 1'b0;

      case (phase_q)
         SQ_IDLE: begin
            if (op_go) begin
               kind_d  = op_kind;
               srs_d   = op_rs;
               byte_d  = op_byte;
               post_d  = op_wait;
               timer_d = 32'd0;
               nib_rs  = op_rs;
               case (op_kind)
                  OP_WAIT: phase_d = SQ_POST;
                  OP_NIB: begin
                     phase_d   = SQ_HI;
                     nib_start = 1'b1;
                     nib_val   = op_byte[3:0];
                  end
                  default: begin
                     phase_d   = SQ_HI;
                     nib_start = 1'b1;
                     nib_val   = op_byte[7:4];
                  end
               endcase
            end
         end
         SQ_HI: begin
            if (nib_done) begin
               timer_d = 32'd0;
               phase_d = (kind_q == OP_BYTE) ? SQ_GAP : SQ_POST;
            end
         end
         SQ_GAP: begin
            if (timer_q == C_1US - 32'd1) begin
               phase_d   = SQ_LO;
               nib_start = 1'b1;
               nib_val   = byte_q[3:0];
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         SQ_LO: begin
            if (nib_done) begin
               timer_d = 32'd0;
               phase_d = SQ_POST;
            end
         end
         SQ_POST: begin
            if (timer_q == post_q - 32'd1) begin
               phase_d  = SQ_IDLE;
               seq_done = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: phase_d = SQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= PWRUP;
         idx_q    <= 2'd0;
         col_q    <= 4'd0;
         snap_a_q <= '0;
         snap_b_q <= '0;
         phase_q  <= SQ_IDLE;
         kind_q   <= OP_WAIT;
         srs_q    <= 1'b0;
         byte_q   <= 8'h00;
         post_q   <= 32'd1;
         timer_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         col_q    <= col_d;
         snap_a_q <= snap_a_d;
         snap_b_q <= snap_b_d;
         phase_q  <= phase_d;
         kind_q   <= kind_d;
         srs_q    <= srs_d;
         byte_q   <= byte_d;
         post_q   <= post_d;
         timer_q  <= timer_d;
      end
   end

   lcd_nibble_tx #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ)
   ) u_nibble_tx (
      .clk    (clk),
      .reset  (reset),
      .start  (nib_start),
      .rs     (nib_rs),
      .nib    (nib_val),
      .lcd_e  (LCD_E),
      .lcd_rs (LCD_RS),
      .lcd_d  (LCD_D),
      .done   (nib_done)
   );

   assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_module.sv
// Bench for lcd_module at 1 MHz (one cycle = 1 us): a bus monitor decodes nibbles on
// E falling edges and checks them against an expected-item queue fed by the stimulus.
module tb_lcd_module;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] row_A;
   logic [127:0] row_B;
   logic         LCD_E;
   logic         LCD_RS;
   logic         LCD_RW;
   logic [3:0]   LCD_D;

   lcd_module #(
      .CLK_FREQ_HZ (1_000_000)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .row_A  (row_A),
      .row_B  (row_B),
      .LCD_E  (LCD_E),
      .LCD_RS (LCD_RS),
      .LCD_RW (LCD_RW),
      .LCD_D  (LCD_D)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       nib;
      logic       rs;
      logic [7:0] val;
   } exp_t;

   exp_t expq[$];
   int   tot = 0;
   int   bad = 0;
   int   cyc = 0;

   // monitor state
   int         run_items = 0;
   logic       e_prev = 1'b0;
   logic       rs_at = 1'b0;
   logic [3:0] d_at = 4'h0;
   int         hi_len = 0;
   int         min_hi = 1_000_000;
   int         stab_viol = 0;
   int         rw_viol = 0;
   logic       have_hi = 1'b0;
   logic [3:0] hi_nib = 4'h0;
   logic       hi_rs = 1'b0;
   int         hi_t = 0;
   logic       rise_seen = 1'b0;
   int         rise_cyc = 0;
   int         rel_cyc = 0;
   int         first_fall[16];
   int         last_fall[16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_nib(input logic [3:0] v);
      expq.push_back('{nib: 1'b1, rs: 1'b0, val: {4'h0, v}});
   endtask

   task automatic push_byte(input logic rs, input logic [7:0] v);
      expq.push_back('{nib: 1'b0, rs: rs, val: v});
   endtask

   task automatic push_init();
      push_nib(4'h3); push_nib(4'h3); push_nib(4'h3); push_nib(4'h2);
      push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
      push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
   endtask

   // One frame as the display should see it: address, 16 chars left to right, twice
   task automatic push_frame(input logic [127:0] a, input logic [127:0] b);
      push_byte(1'b0, 8'h80);
      for (int c = 0; c < 16; c++) push_byte(1'b1, a[8*(15-c) +: 8]);
      push_byte(1'b0, 8'hC0);
      for (int c = 0; c < 16; c++) push_byte(1'b1, b[8*(15-c) +: 8]);
   endtask

   function automatic logic [127:0] rand_row();
      logic [127:0] r;
      for (int c = 0; c < 16; c++) r[8*c +: 8] = 8'($urandom_range(0, 255));
      r[8*$urandom_range(0, 15) +: 8] = 8'h00;
      return r;
   endfunction

   task automatic record_item(input int t_first);
      if (run_items < 16) begin
         first_fall[run_items] = t_first;
         last_fall[run_items]  = cyc;
      end
      run_items++;
   endtask

   task automatic on_nibble(input logic rs, input logic [3:0] d);
      exp_t e;
      if (expq.size() == 0) begin
         have_hi = 1'b0;
      end else if (expq[0].nib) begin
         e = expq.pop_front();
         tot++;
         if (rs !== e.rs || d !== e.val[3:0]) begin
            bad++;
            $display("FAIL item%0d nibble: got rs=%0d d=%h, want rs=%0d d=%h",
                     run_items, rs, d, e.rs, e.val[3:0]);
         end
         record_item(cyc);
      end else if (!have_hi) begin
         have_hi = 1'b1;
         hi_nib  = d;
         hi_rs   = rs;
         hi_t    = cyc;
      end else begin
         e = expq.pop_front();
         tot++;
         if (hi_rs !== e.rs || rs !== e.rs || {hi_nib, d} !== e.val) begin
            bad++;
            $display("FAIL item%0d byte: got rs=%0d/%0d val=%h, want rs=%0d val=%h",
                     run_items, hi_rs, rs, {hi_nib, d}, e.rs, e.val);
         end
         have_hi = 1'b0;
         record_item(hi_t);
      end
   endtask

   always @(negedge clk) begin
      if (LCD_RW !== 1'b0) rw_viol++;
      if (reset) begin
         have_hi   = 1'b0;
         run_items = 0;
         rise_seen = 1'b0;
         e_prev    = 1'b0;
      end else begin
         if (LCD_E && !e_prev) begin
            rs_at  = LCD_RS;
            d_at   = LCD_D;
            hi_len = 1;
            if (!rise_seen) begin
               rise_seen = 1'b1;
               rise_cyc  = cyc;
            end
         end else if (LCD_E && e_prev) begin
            hi_len++;
            if (LCD_RS !== rs_at || LCD_D !== d_at) stab_viol++;
         end else if (!LCD_E && e_prev) begin
            if (hi_len < min_hi) min_hi = hi_len;
            on_nibble(rs_at, d_at);
         end
         e_prev = LCD_E;
      end
   end

   task automatic chk_idle(input string tag);
      tot++;
      if ({LCD_E, LCD_RS, LCD_RW, LCD_D} !== 7'd0) begin
         bad++;
         $display("FAIL %s: bus E,RS,RW,D=%b, want 0000000", tag, {LCD_E, LCD_RS, LCD_RW, LCD_D});
      end
   endtask

   task automatic wait_items(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (run_items < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      tot++;
      if (run_items < n) begin
         bad++;
         $display("FAIL %s: timed out with items=%0d, want >=%0d", tag, run_items, n);
      end
   endtask

   task automatic check_init_timing(input string tag);
      int gmin[8];
      gmin = '{5000, 200, 200, 50, 50, 50, 50, 2000};
      tot++;
      if (!rise_seen || (rise_cyc - rel_cyc) < 20000) begin
         bad++;
         $display("FAIL %s first_e: rise %0d cycles after release, want >=20000", tag, rise_cyc - rel_cyc);
      end
      for (int i = 0; i < 8; i++) begin
         tot++;
         if (first_fall[i+1] - last_fall[i] < gmin[i]) begin
            bad++;
            $display("FAIL %s gap%0d: got %0d us, want >=%0d us", tag, i, first_fall[i+1] - last_fall[i], gmin[i]);
         end
      end
   endtask

   initial begin
      logic [127:0] new_a;
      logic [127:0] new_b;
      int k;

      reset = 1'b1;
      row_A = "welcomeTA's demo";
      row_B = "Press btn3 start";
      repeat (5) begin
         @(negedge clk);
         chk_idle("reset1_idle");
      end
      reset   = 1'b0;
      rel_cyc = cyc;

      push_init();
      push_frame(row_A, row_B);
      push_frame(row_A, row_B);
      wait_items(9, 40000, "init1");
      check_init_timing("run1");

      // Mid line-1 of frame 2: frame 2 keeps its snapshot, frame 3 picks up the change
      wait_items(48, 5000, "f2_mid");
      new_a = "Press btn3 to   ";
      row_A = new_a;
      push_frame(new_a, row_B);

      wait_items(82, 5000, "f3_mid");
      new_a = rand_row();
      new_b = rand_row();
      row_A = new_a;
      row_B = new_b;
      push_frame(new_a, new_b);

      wait_items(116, 5000, "f4_mid");
      new_a = rand_row();
      new_b = rand_row();
      row_A = new_a;
      row_B = new_b;
      push_frame(new_a, new_b);

      wait_items(178, 5000, "f5_end");
      tot++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL queue_run1: %0d items left, want 0", expq.size());
      end

      // Abort in the middle of a strobe
      k = 0;
      while (LCD_E !== 1'b1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      tot++;
      if (LCD_E !== 1'b1) begin
         bad++;
         $display("FAIL e_high_wait: E=%b, want 1", LCD_E);
      end
      reset = 1'b1;
      @(negedge clk);
      tot++;
      if (LCD_E !== 1'b0) begin
         bad++;
         $display("FAIL abort_e: E=%b one clock after reset, want 0", LCD_E);
      end
      repeat (4) begin
         @(negedge clk);
         chk_idle("reset2_idle");
      end
      reset   = 1'b0;
      rel_cyc = cyc;

      push_init();
      push_frame(row_A, row_B);
      wait_items(42, 40000, "run2");
      check_init_timing("run2");

      tot++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL queue_run2: %0d items left, want 0", expq.size());
      end
      tot++;
      if (stab_viol != 0) begin
         bad++;
         $display("FAIL rs_d_stable: %0d changes while E=1, want 0", stab_viol);
      end
      tot++;
      if (rw_viol != 0) begin
         bad++;
         $display("FAIL rw_low: %0d samples with RW!=0, want 0", rw_viol);
      end
      tot++;
      if (min_hi < 1 || min_hi == 1_000_000) begin
         bad++;
         $display("FAIL e_width: min high %0d cycles, want >=1", min_hi);
      end

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
